ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Instruction-fetch controller upstream of the instruction register stage.
- Owns the PC and runs the memory read handshake.
- Delivers the fetched word with a one-cycle IR write-enable pulse, which the IR latches on the next edge.
- Driven by the main DLX control FSM through a start/done handshake.

Parameters:
- AW, 32, PC / memory address width.
- DW, 32, instruction width.
- PC_INC, 1, PC increment after each successful fetch (word addressing).
- TO_CYC, 255, watchdog limit in wait cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_start  in  1  control FSM request for one fetch; sampled only in IDLE
- pc_ld  in  1  load PC from pc_in (jump/branch target)
- pc_in  in  AW  new PC value
- mem_ack  in  1  memory reports rdata valid this cycle
- mem_rdata  in  DW  memory read data
- mem_req  out  1  read request, held until ack
- mem_addr  out  AW  read address (equals PC while requesting)
- ir_en  out  1  one-cycle pulse: IR must capture ir_data
- ir_data  out  DW  registered fetched word
- fetch_done  out  1  one-cycle pulse, same cycle as ir_en
- pc_out  out  AW  current PC
- busy  out  1  high in any state other than IDLE
- fetch_err  out  1  sticky timeout flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; PC=0.
  - mem_req, ir_en, fetch_done, busy, fetch_err all 0.
  - ir_data=0; mem_addr=0.
- State IDLE:
  - fetch_start=1 -> REQ next cycle.
  - pc_ld=1 loads pc_in at the edge.
  - If pc_ld and fetch_start are both high, the fetch uses the new pc_in value.
- State REQ:
  - mem_req=1, mem_addr=PC.
  - mem_ack=1 in this same cycle -> capture mem_rdata into ir_data, go to DONE.
  - Otherwise go to WAIT.
- State WAIT:
  - mem_req stays 1 and mem_addr stays stable.
  - Leave only on mem_ack=1: capture data, go to DONE.
  - mem_ack while not requesting is ignored.
- State DONE:
  - ir_en=1 and fetch_done=1 for exactly one cycle; ir_data is valid.
  - PC <= PC+PC_INC, modulo 2^AW; PC=all-ones wraps to 0.
  - Next state is IDLE.
- Minimum latency: fetch_start to ir_en is 2 cycles (IDLE -> REQ, ack in REQ -> DONE).
- pc_ld outside IDLE is ignored; PC cannot change mid-fetch.
- pc_ld in the DONE cycle is ignored; the increment wins.
- fetch_start outside IDLE is ignored and not queued.
- mem_req is registered (state-decoded from the state register); mem_addr is driven from the PC register, so neither glitches.
- Reset asserted mid-fetch aborts immediately:
  - mem_req drops asynchronously.
  - No ir_en pulse is produced.
  - PC returns to 0.

Optional Feature:
- Macro: IFETCH_TIMEOUT_EN.
- Defined:
  - An 8-bit (or wider, per TO_CYC) wait counter clears on entry to REQ and increments in each WAIT cycle.
  - Reaching TO_CYC without ack: go to IDLE, drop mem_req, set fetch_err=1, pulse fetch_done without ir_en.
  - PC is not incremented.
  - fetch_err clears only on reset, or on the next fetch_start accepted in IDLE.
- Undefined:
  - No counter exists; WAIT is held indefinitely.
  - fetch_err is tied to 0.

Decomposition:
- Shared package holds:
  - State encoding localparams IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3.
  - DLX word width and address width constants, shared with the IR stage.
- One natural sub-module: pc_reg, the PC register with async reset, load and increment inputs, and wrap-around.
- The FSM, data capture and watchdog stay in ifetch_ctrl.

Test Plan:
1. Reset, then fetch_start at PC=0 with mem_ack high in REQ and rdata=32'h8C220004 -> ir_en pulse 2 cycles after start, ir_data=32'h8C220004, pc_out=1 afterwards.
2. mem_ack delayed 5 cycles with rdata=32'h00221820 -> mem_req high for 6 cycles, mem_addr constant, single ir_en pulse, PC increments once.
3. pc_ld with pc_in=32'h40 in IDLE together with fetch_start -> mem_addr=32'h40; after completion pc_out=32'h41. pc_ld pulsed during WAIT -> PC unchanged.
4. rst_n dropped during WAIT -> mem_req=0 immediately, no ir_en, pc_out=0, busy=0.
5. PC loaded to 32'hFFFFFFFF, fetch completes -> pc_out=0.
6. IFETCH_TIMEOUT_EN defined with TO_CYC=8 and no ack -> after 8 WAIT cycles: fetch_done=1, ir_en=0, fetch_err=1, PC unchanged; the next fetch_start clears fetch_err.

Source files
------------

// File: rtl/ifetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller and IR stage.
package ifetch_ctrl_pkg;

    localparam int DLX_AW = 32;
    localparam int DLX_DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    // Watchdog counter runs 0 .. limit-1, so limit itself never has to be stored.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/ifetch_ctrl_pc_reg.sv
// Program counter register: async reset to 0, load, and wrapping increment.
module pc_reg
    import ifetch_ctrl_pkg::*;
#(
    parameter int AW     = DLX_AW,
    parameter int PC_INC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld,
    input  logic [AW-1:0] ld_val,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    // Increment has priority so a late load can never clobber a completed fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + AW'(PC_INC);
        end else if (ld) begin
            pc <= ld_val;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the memory read handshake, pulses IR write.
// Optional watchdog on the memory wait is enabled with the IFETCH_TIMEOUT_EN macro.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter int AW     = DLX_AW,
    parameter int DW     = DLX_DW,
    parameter int PC_INC = 1,
    parameter int TO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_start,
    input  logic          pc_ld,
    input  logic [AW-1:0] pc_in,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          ir_en,
    output logic [DW-1:0] ir_data,
    output logic          fetch_done,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          fetch_err,
    output logic [1:0]    state_dbg
);

    // Handshake: mem_req is held from REQ through WAIT; a cycle with mem_req=1 and
    // mem_ack=1 transfers mem_rdata, and mem_ack is ignored whenever mem_req=0.

    if (TO_CYC < 1) begin : g_to_cyc_check
        $error("TO_CYC must be at least 1");
    end

    fetch_state_t  state;
    logic [DW-1:0] ir_q;
    logic [AW-1:0] pc;
    logic          to_pulse;
    logic          err_q;

`ifdef IFETCH_TIMEOUT_EN
    localparam int            CW       = cnt_width(TO_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TO_CYC - 1);
    logic [CW-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ir_q     <= '0;
            to_pulse <= 1'b0;
            err_q    <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            to_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        state <= REQ;
                        err_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        ir_q  <= mem_rdata;
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        ir_q  <= mem_rdata;
                        state <= DONE;
                    end
`ifdef IFETCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        // Abandon the fetch: report done with error, leave PC untouched.
                        state    <= IDLE;
                        to_pulse <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    pc_reg #(
        .AW     (AW),
        .PC_INC (PC_INC)
    ) u_pc_reg (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     ((state == IDLE) && pc_ld),
        .ld_val (pc_in),
        .inc    (state == DONE),
        .pc     (pc)
    );

    // All outputs decode flops only, so reset removes mem_req without waiting for a clock.
    assign mem_req    = (state == REQ) || (state == WAIT);
    assign mem_addr   = pc;
    assign ir_en      = (state == DONE);
    assign ir_data    = ir_q;
    assign fetch_done = (state == DONE) || to_pulse;
    assign pc_out     = pc;
    assign busy       = (state != IDLE);
    assign state_dbg  = state;
`ifdef IFETCH_TIMEOUT_EN
    assign fetch_err  = err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized fetches against a PC/data model.
module tb_ifetch_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_start = 1'b0;
    logic          pc_ld = 1'b0;
    logic [AW-1:0] pc_in = '0;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          ir_en;
    logic [DW-1:0] ir_data;
    logic          fetch_done;
    logic [AW-1:0] pc_out;
    logic          busy;
    logic          fetch_err;
    logic [1:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    int ir_pulses = 0;

    logic [AW-1:0] model_pc = '0;
    logic [DW-1:0] last_ir = '0;
    logic [DW-1:0] exp_q[$];

    ifetch_ctrl #(
        .AW     (AW),
        .DW     (DW),
        .PC_INC (1),
        .TO_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_start (fetch_start),
        .pc_ld       (pc_ld),
        .pc_in       (pc_in),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .ir_en       (ir_en),
        .ir_data     (ir_data),
        .fetch_done  (fetch_done),
        .pc_out      (pc_out),
        .busy        (busy),
        .fetch_err   (fetch_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ir_en === 1'b1) ir_pulses++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One fetch; ack arrives 'delay' cycles after REQ. 'noise' pokes pc_ld/fetch_start mid-fetch.
    task automatic do_fetch(input bit ld, input logic [AW-1:0] ld_val, input int delay,
                            input logic [DW-1:0] data, input bit noise);
        logic [AW-1:0] addr;
        logic [AW-1:0] next_pc;
        int req_cycles;
        int pulses0;
        addr = ld ? ld_val : model_pc;
        next_pc = addr + 32'd1;
        req_cycles = 0;
        @(negedge clk);
        fetch_start = 1'b1;
        pc_ld = ld;
        pc_in = ld_val;
        mem_ack = 1'b0;
        @(negedge clk);
        fetch_start = 1'b0;
        pc_ld = 1'b0;
        pulses0 = ir_pulses;
        chk("err_cleared_on_start", fetch_err, 1'b0);
        for (int k = 0; k <= delay; k++) begin
            if (mem_req === 1'b1) req_cycles++;
            chk("mem_addr_stable", mem_addr, addr);
            chk("no_early_ir_en", ir_en, 1'b0);
            mem_ack = (k == delay);
            mem_rdata = (k == delay) ? data : DW'($urandom);
            if (k == delay) exp_q.push_back(data);
            if (noise && k == 1 && delay >= 2) begin
                pc_ld = 1'b1;
                pc_in = AW'($urandom);
                fetch_start = 1'b1;
            end else begin
                pc_ld = 1'b0;
                fetch_start = 1'b0;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        mem_rdata = DW'($urandom);
        chk("req_cycles", req_cycles, delay + 1);
        chk("done_ir_en", ir_en, 1'b1);
        chk("done_fetch_done", fetch_done, 1'b1);
        chk("done_mem_req", mem_req, 1'b0);
        chk("done_pc_old", pc_out, addr);
        if (exp_q.size() > 0) begin
            last_ir = exp_q.pop_front();
            chk("ir_data", ir_data, last_ir);
        end
        if (noise) begin
            pc_ld = 1'b1;
            pc_in = AW'($urandom);
        end
        @(negedge clk);
        pc_ld = 1'b0;
        chk("post_ir_en", ir_en, 1'b0);
        chk("post_fetch_done", fetch_done, 1'b0);
        chk("post_busy_not_queued", busy, 1'b0);
        chk("post_pc_inc", pc_out, next_pc);
        chk("single_ir_pulse", ir_pulses - pulses0, 1);
        chk("post_fetch_err", fetch_err, 1'b0);
        model_pc = next_pc;
    endtask

    initial begin
        int pulses_snap;
        logic [AW-1:0] ld_addr;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_ir_en", ir_en, 1'b0);
        chk("rst_fetch_done", fetch_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_ir_data", ir_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_state", state_dbg, 2'd0);
        rst_n = 1'b1;

        // Minimum latency fetch, then a delayed-ack fetch
        do_fetch(1'b0, '0, 0, 32'h8C220004, 1'b0);
        chk("pc_after_first", pc_out, 32'h1);
        do_fetch(1'b0, '0, 5, 32'h00221820, 1'b0);

        // Load together with start; pc_ld / fetch_start during WAIT are ignored
        do_fetch(1'b1, 32'h40, 3, DW'($urandom), 1'b1);
        chk("pc_after_ld_fetch", pc_out, 32'h41);

        // pc_ld alone in IDLE, and a stray ack while idle
        @(negedge clk);
        pc_ld = 1'b1;
        pc_in = 32'h1234;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        pc_ld = 1'b0;
        mem_ack = 1'b0;
        chk("idle_pc_ld", pc_out, 32'h1234);
        chk("idle_ack_ignored_data", ir_data, last_ir);
        chk("idle_ack_ignored_busy", busy, 1'b0);
        model_pc = 32'h1234;

        // PC wrap
        do_fetch(1'b1, 32'hFFFFFFFF, 1, DW'($urandom), 1'b0);
        chk("pc_wrap", pc_out, 32'h0);

        // Reset during WAIT
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        pulses_snap = ir_pulses;
        repeat (2) @(negedge clk);
        chk("pre_abort_mem_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", mem_req, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pc", pc_out, 32'h0);
        chk("abort_ir_en", ir_en, 1'b0);
        mem_ack = 1'b1;
        mem_rdata = DW'($urandom);
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        chk("abort_no_pulse", ir_pulses - pulses_snap, 0);
        rst_n = 1'b1;
        model_pc = '0;
        last_ir = '0;

        // Randomized fetches
        for (int n = 0; n < 20; n++) begin
            ld_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : AW'($urandom);
            do_fetch($urandom_range(0, 2) == 0, ld_addr, $urandom_range(0, 6),
                     DW'($urandom), $urandom_range(0, 1) == 1);
        end

`ifdef IFETCH_TIMEOUT_EN
        // Watchdog: no ack for 8 WAIT cycles
        @(negedge clk);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk("to_mem_req_held", mem_req, 1'b1);
            @(negedge clk);
        end
        chk("to_fetch_done", fetch_done, 1'b1);
        chk("to_ir_en", ir_en, 1'b0);
        chk("to_fetch_err", fetch_err, 1'b1);
        chk("to_mem_req", mem_req, 1'b0);
        chk("to_busy", busy, 1'b0);
        chk("to_pc_unchanged", pc_out, model_pc);
        @(negedge clk);
        chk("to_done_one_cycle", fetch_done, 1'b0);
        chk("to_err_sticky", fetch_err, 1'b1);
        do_fetch(1'b0, '0, 2, DW'($urandom), 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
